// File: rtl/poly_mult_pkg.sv
// Shared state encoding, ring-mode constants and sizing helpers for the tiled polynomial multiplier.
// Latency: not applicable, declarations only.
// Backpressure: not applicable.
package poly_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Reduction polynomial selection: x^N+1 folds with subtraction, x^N-1 with addition.
    localparam int RING_NEGACYCLIC = 0;
    localparam int RING_CYCLIC     = 1;

    // Number of tiles per operand polynomial.
    function automatic int tile_count(input int poly_width, input int tile_width);
        return poly_width / tile_width;
    endfunction

    // Counter/index width able to address n entries; never narrower than one bit.
    function automatic int index_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/poly_mult_tiled_mod_mac.sv
// One modular multiply-accumulate lane: acc +/- a*b, reduced into [0, q-1].
// Latency: purely combinational.
// Backpressure: none; the owner decides when the result is written back.
module poly_mod_mac
    import poly_mult_pkg::*;
#(
    parameter int                    DATA_WIDTH = 64,
    parameter logic [DATA_WIDTH-1:0] MODULUS    = {DATA_WIDTH{1'b1}}
) (
    input  logic [DATA_WIDTH-1:0] acc_in,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  sub,
    output logic [DATA_WIDTH-1:0] acc_out
);

    logic [2*DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0]   prod_mod;
    logic [DATA_WIDTH:0]     sum;

    // Full-width product, reduce it, then add or subtract modulo q (acc_in is already < q).
    always_comb begin
        prod     = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
        prod_mod = DATA_WIDTH'(prod % {{DATA_WIDTH{1'b0}}, MODULUS});
        sum      = {1'b0, acc_in} + {1'b0, prod_mod};
        if (sub) begin
            acc_out = (acc_in >= prod_mod) ? (acc_in - prod_mod)
                                           : (acc_in + (MODULUS - prod_mod));
        end else begin
            acc_out = (sum >= {1'b0, MODULUS}) ? DATA_WIDTH'(sum - {1'b0, MODULUS})
                                               : DATA_WIDTH'(sum);
        end
    end

endmodule

// File: rtl/poly_mult_tiled_mod.sv
// Tiled polynomial multiplier C = A*B mod (x^N +/- 1, q), fed as T^2 tile pairs, drained as T tiles.
// Latency: TILE_WIDTH+1 cycles per pair (IDLE accept + MAC), then T drain beats and a one-cycle DONE.
// Backpressure: in_ready only in IDLE; drain holds c_tile stable while out_ready is low.
module poly_mult_tiled_mod
    import poly_mult_pkg::*;
#(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    POLY_WIDTH = 64,
    parameter int                    TILE_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] MODULUS    = {DATA_WIDTH{1'b1}},
    parameter int                    RING_MODE  = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [TILE_WIDTH*DATA_WIDTH-1:0] tile_a,
    input  logic [TILE_WIDTH*DATA_WIDTH-1:0] tile_b,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [TILE_WIDTH*DATA_WIDTH-1:0] c_tile,
    output logic                             out_last,
    output logic                             busy,
    output logic                             done
);

    localparam int  DW         = DATA_WIDTH;
    localparam int  N          = POLY_WIDTH;
    localparam int  TW         = TILE_WIDTH;
    localparam int  T          = tile_count(POLY_WIDTH, TILE_WIDTH);
    localparam int  TIW        = index_width(T);
    localparam int  KW         = index_width(TW);
    localparam int  AW         = index_width(N);
    localparam int  GW         = AW + 1;
    localparam bit  NEGACYCLIC = (RING_MODE != RING_CYCLIC);

    state_t               state;
    state_t               state_nxt;
    logic [TW*DW-1:0]     a_reg;
    logic [TW*DW-1:0]     b_reg;
    logic [TIW-1:0]       i_cnt;
    logic [TIW-1:0]       j_cnt;
    logic [TIW-1:0]       d_cnt;
    logic [KW-1:0]        k_cnt;
    logic [DW-1:0]        acc [N];

    logic                 k_last;
    logic                 j_last;
    logic                 i_last;
    logic                 d_last;
    logic [DW-1:0]        a_k;
    logic [AW-1:0]        acc_idx [TW];
    logic                 fold_sub [TW];
    logic [DW-1:0]        mac_out [TW];
    logic [TW*DW-1:0]     drain_tile;

    assign k_last = (k_cnt == KW'(TW - 1));
    assign j_last = (j_cnt == TIW'(T - 1));
    assign i_last = (i_cnt == TIW'(T - 1));
    assign d_last = (d_cnt == TIW'(T - 1));

    // Select coefficient k of the held a-tile for this MAC cycle.
    always_comb begin
        a_k = '0;
        for (int k = 0; k < TW; k++) begin
            if (k_cnt == KW'(k)) a_k = a_reg[k*DW +: DW];
        end
    end

    // Global product degree for each lane, folded back below N; folded terms flip sign in the negacyclic ring.
    always_comb begin
        logic [GW-1:0] tgt;
        for (int l = 0; l < TW; l++) begin
            tgt = GW'(int'(i_cnt) * TW + int'(k_cnt) + int'(j_cnt) * TW + l);
            if (tgt >= GW'(N)) begin
                acc_idx[l]  = AW'(tgt - GW'(N));
                fold_sub[l] = NEGACYCLIC;
            end else begin
                acc_idx[l]  = AW'(tgt);
                fold_sub[l] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < TW; g++) begin : g_mac
        poly_mod_mac #(
            .DATA_WIDTH (DW),
            .MODULUS    (MODULUS)
        ) u_mac (
            .acc_in  (acc[acc_idx[g]]),
            .a       (a_k),
            .b       (b_reg[g*DW +: DW]),
            .sub     (fold_sub[g]),
            .acc_out (mac_out[g])
        );
    end

    // Gather the accumulator tile addressed by the drain counter.
    always_comb begin
        drain_tile = '0;
        for (int t = 0; t < T; t++) begin
            if (d_cnt == TIW'(t)) begin
                for (int l = 0; l < TW; l++) drain_tile[l*DW +: DW] = acc[t*TW + l];
            end
        end
    end

    // State register; reset always lands in IDLE, abandoning any job in flight.
    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next-state and handshake outputs; every output is forced low while reset is asserted.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        c_tile    = '0;
        case (state)
            ST_IDLE: begin
                in_ready = rst;
                busy     = rst && ((i_cnt != '0) || (j_cnt != '0));
                if (in_valid) state_nxt = ST_MAC;
            end
            ST_MAC: begin
                busy = rst;
                if (k_last) state_nxt = (i_last && j_last) ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                busy      = rst;
                out_valid = rst;
                out_last  = rst && d_last;
                c_tile    = rst ? drain_tile : '0;
                if (out_ready && d_last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                busy      = rst;
                done      = rst;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Tile capture, MAC row write-back, pair/drain counters and accumulator clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_reg <= '0;
            b_reg <= '0;
            i_cnt <= '0;
            j_cnt <= '0;
            d_cnt <= '0;
            k_cnt <= '0;
            for (int m = 0; m < N; m++) acc[m] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_reg <= tile_a;
                        b_reg <= tile_b;
                        k_cnt <= '0;
                    end
                end
                ST_MAC: begin
                    for (int l = 0; l < TW; l++) acc[acc_idx[l]] <= mac_out[l];
                    if (k_last) begin
                        k_cnt <= '0;
                        if (j_last) begin
                            j_cnt <= '0;
                            i_cnt <= i_last ? '0 : i_cnt + TIW'(1);
                        end else begin
                            j_cnt <= j_cnt + TIW'(1);
                        end
                    end else begin
                        k_cnt <= k_cnt + KW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) d_cnt <= d_last ? '0 : d_cnt + TIW'(1);
                end
                ST_DONE: begin
                    for (int m = 0; m < N; m++) acc[m] <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_mult_tiled_mod.sv
module tb_poly_mult_tiled_mod;

    localparam int DW = 8;
    localparam int N  = 16;
    localparam int TW = 4;
    localparam int T  = N / TW;
    localparam int Q  = 17;

    typedef logic [N*DW-1:0]  poly_t;
    typedef logic [TW*DW-1:0] tile_t;

    typedef struct {
        string name;
        poly_t a;
        poly_t b;
        poly_t exp0;
        poly_t exp1;
        bit    stall;
    } vec_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  in_valid;
    logic  out_ready;
    tile_t tile_a;
    tile_t tile_b;

    logic  in_ready0, out_valid0, out_last0, busy0, done0;
    logic  in_ready1, out_valid1, out_last1, busy1, done1;
    tile_t c_tile0, c_tile1;

    always #5 clk = ~clk;

    poly_mult_tiled_mod #(
        .DATA_WIDTH (DW), .POLY_WIDTH (N), .TILE_WIDTH (TW), .MODULUS (8'd17), .RING_MODE (0)
    ) dut0 (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready0),
        .tile_a (tile_a), .tile_b (tile_b), .out_valid (out_valid0), .out_ready (out_ready),
        .c_tile (c_tile0), .out_last (out_last0), .busy (busy0), .done (done0)
    );

    poly_mult_tiled_mod #(
        .DATA_WIDTH (DW), .POLY_WIDTH (N), .TILE_WIDTH (TW), .MODULUS (8'd17), .RING_MODE (1)
    ) dut1 (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready1),
        .tile_a (tile_a), .tile_b (tile_b), .out_valid (out_valid1), .out_ready (out_ready),
        .c_tile (c_tile1), .out_last (out_last1), .busy (busy1), .done (done1)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Observation queues filled by the monitor; tasks only read them.
    int    cap_cyc[$];
    tile_t q0[$];
    tile_t q1[$];
    logic  lastq[$];
    int    done0_n = 0;
    int    done1_n = 0;
    int    done_cyc = 0;
    int    hs_cyc = 0;

    vec_t  vecs[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (in_valid && in_ready0) cap_cyc.push_back(cyc);
            if (out_valid0 && out_ready) begin
                q0.push_back(c_tile0);
                lastq.push_back(out_last0);
                hs_cyc = cyc;
            end
            if (out_valid1 && out_ready) q1.push_back(c_tile1);
            if (done0) begin
                done0_n++;
                done_cyc = cyc;
            end
            if (done1) done1_n++;
        end
    end

    task automatic check(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Plain schoolbook product with wrap-around folding, straight from the ring definition.
    function automatic poly_t ref_mul(input poly_t a, input poly_t b, input int mode);
        int    c [N];
        int    t;
        int    v;
        poly_t r;
        for (int k = 0; k < N; k++) c[k] = 0;
        for (int p = 0; p < N; p++) begin
            for (int s = 0; s < N; s++) begin
                t = p + s;
                v = int'(a[p*DW +: DW]) * int'(b[s*DW +: DW]);
                if (t >= N) begin
                    t = t - N;
                    if (mode == 0) v = -v;
                end
                c[t] = ((c[t] + v) % Q + Q) % Q;
            end
        end
        r = '0;
        for (int k = 0; k < N; k++) r[k*DW +: DW] = 8'(c[k]);
        return r;
    endfunction

    task automatic add_vec(input string name, input poly_t a, input poly_t b,
                           input poly_t e0, input poly_t e1, input bit stall);
        vec_t v;
        v.name = name; v.a = a; v.b = b; v.exp0 = e0; v.exp1 = e1; v.stall = stall;
        vecs.push_back(v);
    endtask

    // Offer one tile pair and return after the edge on which it transfers.
    task automatic send_pair(input string tag, input tile_t ta, input tile_t tbv);
        int guard;
        tile_a   = ta;
        tile_b   = tbv;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready0 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) timeout({tag, "_in_ready"});
        @(posedge clk); #1;
    endtask

    task automatic run_job(input vec_t v);
        int cap_base = cap_cyc.size();
        int q_base   = q0.size();
        int q1_base  = q1.size();
        int d0       = done0_n;
        int d1       = done1_n;
        int guard;
        int bad_gap;
        int n_tiles;

        check({v.name, "_busy_start"}, 128'(busy0), 128'(0));
        out_ready = !v.stall;
        for (int i = 0; i < T; i++) begin
            for (int j = 0; j < T; j++) begin
                send_pair(v.name, v.a[i*TW*DW +: TW*DW], v.b[j*TW*DW +: TW*DW]);
                if (i == 0 && j == 1) check({v.name, "_busy_mid"}, 128'(busy0), 128'(1));
            end
        end
        in_valid = 1'b0;

        if (v.stall) begin
            guard = 0;
            while (!out_valid0 && guard < 100) begin
                @(posedge clk); #1;
                guard++;
            end
            if (guard >= 100) timeout({v.name, "_drain_start"});
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
                check({v.name, "_stall_valid"}, 128'(out_valid0), 128'(1));
                check({v.name, "_stall_tile"}, 128'(c_tile0), 128'(v.exp0[1*TW*DW +: TW*DW]));
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
        end

        guard = 0;
        while (done0_n == d0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) timeout({v.name, "_done"});
        repeat (3) begin
            @(posedge clk); #1;
        end

        check({v.name, "_captures"}, 128'(cap_cyc.size() - cap_base), 128'(T * T));
        bad_gap = 0;
        for (int c = cap_base + 1; c < cap_cyc.size(); c++) begin
            if (cap_cyc[c] - cap_cyc[c-1] != TW + 1) bad_gap++;
        end
        check({v.name, "_capture_gaps"}, 128'(bad_gap), 128'(0));

        check({v.name, "_tiles0"}, 128'(q0.size() - q_base), 128'(T));
        check({v.name, "_tiles1"}, 128'(q1.size() - q1_base), 128'(T));
        n_tiles = (q0.size() - q_base < T) ? q0.size() - q_base : T;
        for (int t = 0; t < n_tiles; t++) begin
            check({v.name, "_c0_tile"}, 128'(q0[q_base+t]), 128'(v.exp0[t*TW*DW +: TW*DW]));
            check({v.name, "_last"}, 128'(lastq[q_base+t]), 128'(t == T - 1));
        end
        n_tiles = (q1.size() - q1_base < T) ? q1.size() - q1_base : T;
        for (int t = 0; t < n_tiles; t++) begin
            check({v.name, "_c1_tile"}, 128'(q1[q1_base+t]), 128'(v.exp1[t*TW*DW +: TW*DW]));
        end

        check({v.name, "_done0_once"}, 128'(done0_n - d0), 128'(1));
        check({v.name, "_done1_once"}, 128'(done1_n - d1), 128'(1));
        check({v.name, "_done_timing"}, 128'(done_cyc), 128'(hs_cyc + 1));
        check({v.name, "_idle_ready"}, 128'(in_ready0), 128'(1));
        check({v.name, "_idle_busy"}, 128'(busy0), 128'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 128'(in_ready0), 128'(0));
        check({tag, "_out_valid"}, 128'({out_valid0, out_valid1}), 128'(0));
        check({tag, "_out_last"}, 128'({out_last0, out_last1}), 128'(0));
        check({tag, "_busy"}, 128'({busy0, busy1}), 128'(0));
        check({tag, "_done"}, 128'({done0, done1}), 128'(0));
        check({tag, "_c_tile"}, 128'({c_tile0, c_tile1}), 128'(0));
    endtask

    initial begin
        poly_t ones;
        poly_t x1;
        poly_t x15;
        poly_t ra;
        poly_t rb;

        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tile_a    = '0;
        tile_b    = '0;

        ones = {N{8'h01}};
        x1   = poly_t'(1) << DW;
        x15  = poly_t'(1) << (15 * DW);
        add_vec("ones", ones, ones, 128'h100e0c0a08060402_000f0d0b09070503, {N{8'h10}}, 1'b0);
        add_vec("x_x15", x1, x15, 128'h10, 128'h01, 1'b0);
        add_vec("ones_stall", ones, ones, 128'h100e0c0a08060402_000f0d0b09070503, {N{8'h10}}, 1'b1);
        for (int r = 0; r < 3; r++) begin
            ra = '0;
            rb = '0;
            for (int k = 0; k < N; k++) begin
                ra[k*DW +: DW] = 8'($urandom_range(0, Q - 1));
                rb[k*DW +: DW] = 8'($urandom_range(0, Q - 1));
            end
            add_vec($sformatf("rand%0d", r), ra, rb, ref_mul(ra, rb, 0), ref_mul(ra, rb, 1), r == 1);
        end

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        #1;
        check("release_in_ready", 128'(in_ready0), 128'(1));

        for (int v = 0; v < vecs.size(); v++) run_job(vecs[v]);

        // Abort mid-job after 7 pairs, then a clean all-ones job must match the fresh result.
        out_ready = 1'b1;
        for (int p = 0; p < 7; p++) begin
            send_pair("abort", ones[(p / T)*TW*DW +: TW*DW], ones[(p % T)*TW*DW +: TW*DW]);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("abort_rst_in_ready", 128'(in_ready0), 128'(0));
        @(posedge clk); #1;
        check_reset_outputs("abort_rst");
        rst = 1'b1;
        #1;
        check("abort_release_ready", 128'(in_ready0), 128'(1));
        check("abort_release_busy", 128'(busy0), 128'(0));
        run_job(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/poly_mult_tiled_mod.md
POLY_MULT_TILED_MOD -- requirements
Module: poly_mult_tiled_mod

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, coefficient width in bits.
REQ-002 SHALL have parameter POLY_WIDTH, default 64, coefficients per operand polynomial (N).
REQ-003 SHALL have parameter TILE_WIDTH, default 8, coefficients per tile; POLY_WIDTH % TILE_WIDTH == 0; T = POLY_WIDTH/TILE_WIDTH.
REQ-004 SHALL have parameter MODULUS, default 2^DATA_WIDTH-1, coefficient modulus q (q >= 2).
REQ-005 SHALL have parameter RING_MODE, default 0: 0 = negacyclic (x^N+1), 1 = cyclic (x^N-1).
REQ-006 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-008 SHALL have ports in_valid input 1 and in_ready output 1: tile-pair handshake.
REQ-009 SHALL have ports tile_a and tile_b, input, TILE_WIDTH*DATA_WIDTH each: coefficient 0 in LSBs, values < q.
REQ-010 SHALL have ports out_valid output 1 and out_ready input 1: result handshake.
REQ-011 SHALL have port c_tile  output  TILE_WIDTH*DATA_WIDTH  result tile, coefficient 0 in LSBs.
REQ-012 SHALL have ports out_last output 1 (final result tile), busy output 1, done output 1 (one-cycle pulse).

Function
REQ-013 SHALL compute C = A*B mod (x^N+1) or mod (x^N-1) per RING_MODE, every coefficient reduced into [0, q-1].
REQ-014 SHALL accept exactly T^2 tile pairs per job, ordered a-tile i outer, b-tile j inner; a pair transfers when in_valid && in_ready.
REQ-015 SHALL use FSM IDLE -> MAC -> (IDLE-accept | DRAIN) -> DONE -> IDLE; in_ready = 1 only in IDLE, held internal tile registers capture on handshake.
REQ-016 SHALL in MAC spend exactly TILE_WIDTH cycles per pair, cycle k adding a_k*b_l for all l into acc[(i*TILE_WIDTH+k)+(j*TILE_WIDTH+l)].
REQ-017 SHALL, for target index m >= N, write acc[m-N] with the product subtracted (mode 0) or added (mode 1), modulo q.
REQ-018 SHALL return to IDLE after MAC unless the T^2-th pair is done, then enter DRAIN.
REQ-019 SHALL in DRAIN present T result tiles in order 0..T-1, out_valid = 1, c_tile stable while out_ready = 0; out_last = 1 with tile T-1.
REQ-020 SHALL pulse done for one cycle in DONE (cycle after final output handshake), clear accumulator, return to IDLE.
REQ-021 SHALL hold busy = 1 in any state except IDLE with zero pairs accepted for the current job.
REQ-022 SHALL ignore in_valid outside IDLE (no capture, no error); out_ready outside DRAIN has no effect.
REQ-023 SHALL wrap internal pair counters (i, j) and drain counter exactly at T-1 -> 0 on job completion.

Reset
REQ-024 SHALL, when rst = 0 at a rising edge, enter IDLE, clear accumulator, counters and tile registers to 0, drive in_ready = 0, out_valid = 0, out_last = 0, busy = 0, done = 0, c_tile = 0.
REQ-025 SHALL abort any job on reset mid-MAC or mid-DRAIN; partial results are discarded, first cycle after release has in_ready = 1.

Structure
REQ-026 SHALL place the FSM state enum, ring-mode constants and the tile-count/index-width localparams in shared package poly_mult_pkg.
REQ-027 SHALL instantiate TILE_WIDTH copies of sub-module poly_mod_mac (acc +/- a*b mod q, combinational, 2*DATA_WIDTH product) for the per-cycle MAC row.
REQ-028 SHALL keep the accumulator as N registers of DATA_WIDTH; no RAM macro.

Verification (bench params: DATA_WIDTH=8, POLY_WIDTH=16, TILE_WIDTH=4, MODULUS=17)
REQ-029 SHALL verify all-ones A,B, RING_MODE=0 -> c_k = (2k+2-16) mod 17: c_0=3, c_7=0, c_15=16; done pulses once.
REQ-030 SHALL verify all-ones A,B, RING_MODE=1 -> all 16 coefficients = 16.
REQ-031 SHALL verify A=x, B=x^15, RING_MODE=0 -> c_0=16, all others 0; RING_MODE=1 -> c_0=1.
REQ-032 SHALL verify out_ready held low 5 cycles during DRAIN tile 1 -> c_tile unchanged, out_valid stays 1, no tile skipped.
REQ-033 SHALL verify rst=0 for 1 cycle after 7 of 16 pairs, then a fresh all-ones job -> result identical to REQ-029.
REQ-034 SHALL verify in_valid held high continuously -> exactly 16 captures, one per IDLE visit, spaced TILE_WIDTH+1 cycles.
